// File: rtl/hc194_deser_if.sv
// Bundle for the deserializer: serial line and strobes in, held word and status out.
// The master side drives the serial line and READY; the slave side is the receiver.
interface hc194_deser_if #(
    parameter int WIDTH = 4
) ();
    localparam int CW = $clog2(WIDTH);

    logic             ds;
    logic             sen;
    logic             dir;
    logic             sync;
    logic             ready;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             ovr;
    logic [CW-1:0]    cnt;

    modport master (
        output ds, sen, dir, sync, ready,
        input  q, valid, ovr, cnt
    );

    modport slave (
        input  ds, sen, dir, sync, ready,
        output q, valid, ovr, cnt
    );
endinterface

// File: rtl/hc194_deser.sv
// Serial-to-parallel receiver for an HC194-style link.
// It presents each completed word on a one-entry valid/ready register and flags overruns.
//
// state | meaning
// EMPTY | no unconsumed word held, valid=0
// FULL  | q holds an unconsumed word, valid=1
module hc194_deser #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic mr,
    hc194_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] q_r;
    logic [CW-1:0]    bc;
    logic             ldir;
    logic             ovr_r;

    logic             dir_eff;
    logic             last_bit;
    logic             word_done;
    logic [WIDTH-1:0] shifted;

    // Direction is captured on the first bit of a frame, so it is taken live only while bc=0.
    always_comb begin
        dir_eff   = (bc == '0) ? bus.dir : ldir;
        shifted   = dir_eff ? {bus.ds, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.ds};
        last_bit  = (bc == CW'(WIDTH - 1));
        word_done = bus.sen && !bus.sync && last_bit;
    end

    always_ff @(posedge clk) begin
        if (mr) begin
            sr    <= '0;
            bc    <= '0;
            ldir  <= 1'b0;
            q_r   <= '0;
            ovr_r <= 1'b0;
            state <= EMPTY;
        end else begin
            if (bus.sync) begin
                sr <= '0;
                bc <= '0;
            end else if (bus.sen) begin
                if (bc == '0)
                    ldir <= bus.dir;
                if (last_bit) begin
                    sr <= '0;
                    bc <= '0;
                end else begin
                    sr <= shifted;
                    bc <= bc + CW'(1);
                end
            end

            case (state)
                EMPTY: begin
                    if (word_done) begin
                        q_r   <= shifted;
                        state <= FULL;
                    end
                end
                FULL: begin
                    // A word landing on the consume edge replaces the held one without a bubble.
                    if (word_done) begin
                        if (bus.ready)
                            q_r <= shifted;
                        else
                            ovr_r <= 1'b1;
                    end else if (bus.ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.q     = q_r;
    assign bus.valid = (state == FULL);
    assign bus.ovr   = ovr_r;
    assign bus.cnt   = bc;
endmodule

// File: tb/tb_hc194_deser.sv
// Directed bench for hc194_deser at WIDTH=4.
// Inputs are driven between edges; outputs are sampled 1ns after each rising edge.
module tb_hc194_deser;
    logic clk;
    logic mr;
    int   checks;
    int   failures;

    hc194_deser_if #(.WIDTH(4)) bus ();

    hc194_deser #(.WIDTH(4)) dut (
        .clk (clk),
        .mr  (mr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ds_v, input logic sen_v);
        bus.ds  = ds_v;
        bus.sen = sen_v;
        @(posedge clk);
        #1;
        bus.sen = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        mr         = 1'b1;
        bus.ds     = 1'b0;
        bus.sen    = 1'b0;
        bus.dir    = 1'b0;
        bus.sync   = 1'b0;
        bus.ready  = 1'b0;

        // reset
        step(1'b0, 1'b0);
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_ovr", 32'(bus.ovr), 32'h0);
        chk("rst_cnt", 32'(bus.cnt), 32'h0);
        mr = 1'b0;

        // right shift, 1,0,1,1 -> B
        bus.dir = 1'b0; bus.ready = 1'b1;
        step(1'b1, 1'b1); chk("r_cnt1", 32'(bus.cnt), 32'h1);
        step(1'b0, 1'b1); chk("r_cnt2", 32'(bus.cnt), 32'h2);
        step(1'b1, 1'b1); chk("r_cnt3", 32'(bus.cnt), 32'h3);
        chk("r_valid_pre", 32'(bus.valid), 32'h0);
        step(1'b1, 1'b1); chk("r_cnt0", 32'(bus.cnt), 32'h0);
        chk("r_q", 32'(bus.q), 32'hB);
        chk("r_valid", 32'(bus.valid), 32'h1);
        step(1'b0, 1'b0); chk("r_consumed", 32'(bus.valid), 32'h0);
        chk("r_q_hold", 32'(bus.q), 32'hB);

        // left shift, 1,0,1,1 -> D
        bus.dir = 1'b1;
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        chk("l_q", 32'(bus.q), 32'hD);
        chk("l_valid", 32'(bus.valid), 32'h1);
        step(1'b0, 1'b0);

        // direction changed after the first bit is ignored
        bus.dir = 1'b1;
        step(1'b1, 1'b1);
        bus.dir = 1'b0;
        step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        chk("ldir_q", 32'(bus.q), 32'hD);
        step(1'b0, 1'b0);

        // gapped strobe, right shift
        bus.dir = 1'b0;
        step(1'b1, 1'b1); chk("g_cnt1", 32'(bus.cnt), 32'h1);
        step(1'b0, 1'b0); chk("g_gap1", 32'(bus.cnt), 32'h1);
        step(1'b0, 1'b1); chk("g_cnt2", 32'(bus.cnt), 32'h2);
        step(1'b1, 1'b0); chk("g_gap2", 32'(bus.cnt), 32'h2);
        step(1'b1, 1'b1); chk("g_cnt3", 32'(bus.cnt), 32'h3);
        step(1'b0, 1'b0); chk("g_gap3", 32'(bus.cnt), 32'h3);
        step(1'b1, 1'b1);
        chk("g_q", 32'(bus.q), 32'hB);
        chk("g_valid", 32'(bus.valid), 32'h1);
        step(1'b0, 1'b0); chk("g_consumed", 32'(bus.valid), 32'h0);

        // backpressure and overrun
        bus.ready = 1'b0;
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        chk("o_q1", 32'(bus.q), 32'hB);
        chk("o_ovr_pre", 32'(bus.ovr), 32'h0);
        step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        chk("o_q2", 32'(bus.q), 32'hB);
        chk("o_valid2", 32'(bus.valid), 32'h1);
        chk("o_ovr", 32'(bus.ovr), 32'h1);
        bus.ready = 1'b1;
        step(1'b0, 1'b0);
        chk("o_consumed", 32'(bus.valid), 32'h0);
        chk("o_ovr_sticky", 32'(bus.ovr), 32'h1);
        step(1'b0, 1'b0);
        chk("o_ovr_sticky2", 32'(bus.ovr), 32'h1);
        mr = 1'b1;
        step(1'b0, 1'b0);
        mr = 1'b0;
        chk("o_ovr_mr", 32'(bus.ovr), 32'h0);

        // back-to-back: second word lands on the consume edge of the first
        bus.ready = 1'b0;
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        chk("b_q1", 32'(bus.q), 32'hB);
        step(1'b0, 1'b1); chk("b_valid5", 32'(bus.valid), 32'h1);
        step(1'b1, 1'b1); chk("b_valid6", 32'(bus.valid), 32'h1);
        step(1'b1, 1'b1); chk("b_valid7", 32'(bus.valid), 32'h1);
        bus.ready = 1'b1;
        step(1'b0, 1'b1);
        chk("b_q2", 32'(bus.q), 32'h6);
        chk("b_valid8", 32'(bus.valid), 32'h1);
        chk("b_ovr", 32'(bus.ovr), 32'h0);
        step(1'b0, 1'b0); chk("b_consumed", 32'(bus.valid), 32'h0);

        // SYNC mid-frame discards the partial word and the concurrent bit
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        chk("s_cnt2", 32'(bus.cnt), 32'h2);
        bus.sync = 1'b1;
        step(1'b1, 1'b1);
        bus.sync = 1'b0;
        chk("s_cnt0", 32'(bus.cnt), 32'h0);
        chk("s_valid", 32'(bus.valid), 32'h0);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        chk("s_q", 32'(bus.q), 32'hC);
        chk("s_valid_word", 32'(bus.valid), 32'h1);
        step(1'b0, 1'b0);

        // MR mid-frame clears everything, next SEN starts a fresh frame
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        mr = 1'b1;
        step(1'b1, 1'b1);
        mr = 1'b0;
        chk("m_q", 32'(bus.q), 32'h0);
        chk("m_valid", 32'(bus.valid), 32'h0);
        chk("m_ovr", 32'(bus.ovr), 32'h0);
        chk("m_cnt", 32'(bus.cnt), 32'h0);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        chk("m_q_after", 32'(bus.q), 32'hC);
        chk("m_valid_after", 32'(bus.valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
